// File: rtl/readback_buffer_if.sv
// Readback buffer bus: PHY return beats, reservations and host stream.
interface readback_buffer_if;
  logic         rd_valid;
  logic [511:0] rd_data;
  logic [11:0]  read_size;
  logic         read_seq_incoming;
  logic         softmc_end;
  logic [11:0]  buffer_space;
  logic [511:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         done;
  logic         ovf_err;

  modport master (
    output rd_valid, rd_data, read_size,
    output read_seq_incoming, softmc_end, out_ready,
    input  buffer_space, out_data, out_valid,
    input  out_last, done, ovf_err
  );

  modport slave (
    input  rd_valid, rd_data, read_size,
    input  read_seq_incoming, softmc_end, out_ready,
    output buffer_space, out_data, out_valid,
    output out_last, done, ovf_err
  );
endinterface

// File: rtl/readback_buffer.sv
// DDR read-return buffer streaming beats to the host with reservations.
// Optional overflow flag enabled by defining READBACK_OVF_CHECK_EN.
module readback_buffer #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input logic              clk,
  input logic              rst,
  readback_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  localparam logic [12:0] DEPTH_C = 13'(DEPTH);
  localparam logic [13:0] DEPTH_W = 14'(DEPTH);

  logic [511:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [12:0]   occ;
  logic [12:0]   res;
  state_t        state;
  logic          armed;

  logic          full;
  logic          wr;
  logic          rd;
  logic          load;
  logic          ram_empty;
  logic          bypass;
  logic          end_ev;
  logic          go_drain;
  logic [12:0]   add;
  logic [12:0]   res_n;
  logic [12:0]   occ_n;
  logic [13:0]   used;
  logic [11:0]   space_n;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // occ includes the output register, so RAM is empty when occ == out_valid
  always_comb begin
    full      = occ == DEPTH_C;
    wr        = bus.rd_valid && !full;
    rd        = bus.out_valid && bus.out_ready;
    load      = !bus.out_valid || bus.out_ready;
    ram_empty = occ == {12'd0, bus.out_valid};
    bypass    = load && ram_empty && wr;
    add       = bus.read_seq_incoming ? {1'b0, bus.read_size} : '0;
    res_n     = res + add;
    if (wr && res_n != 13'd0)
      res_n = res_n - 13'd1;
    occ_n     = occ + {12'd0, wr} - {12'd0, rd};
    used      = {1'b0, occ_n} + {1'b0, res_n};
    space_n   = (used >= DEPTH_W) ? '0 : 12'(DEPTH_W - used);
    end_ev    = bus.softmc_end && armed;
    go_drain  = end_ev &&
                ((state == S_RUN) ||
                 (state == S_IDLE && occ == 13'd0));
  end

  always_ff @(posedge clk) begin
    if (wr && !bypass)
      mem[wr_ptr] <= bus.rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      occ              <= '0;
      res              <= '0;
      state            <= S_IDLE;
      armed            <= 1'b1;
      bus.buffer_space <= '0;
      bus.out_data     <= '0;
      bus.out_valid    <= 1'b0;
      bus.done         <= 1'b0;
    end else begin
      occ              <= occ_n;
      res              <= res_n;
      bus.buffer_space <= space_n;
      bus.done         <= 1'b0;
      if (wr && !bypass)
        wr_ptr <= nxt(wr_ptr);
      if (load) begin
        if (!ram_empty) begin
          bus.out_data  <= mem[rd_ptr];
          bus.out_valid <= 1'b1;
          rd_ptr        <= nxt(rd_ptr);
        end else if (wr) begin
          bus.out_data  <= bus.rd_data;
          bus.out_valid <= 1'b1;
        end else begin
          bus.out_valid <= 1'b0;
        end
      end
      // end request is edge-armed so a held level cannot restart a run
      if (!bus.softmc_end)
        armed <= 1'b1;
      else if (go_drain)
        armed <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (go_drain)
            state <= S_DRAIN;
          else if (bus.read_seq_incoming || bus.rd_valid)
            state <= S_RUN;
        end
        S_RUN: begin
          if (go_drain)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (res_n == 13'd0 && occ_n == 13'd0) begin
            state    <= S_FIN;
            bus.done <= 1'b1;
          end
        end
        S_FIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_last = bus.out_valid && state == S_DRAIN &&
                        res == 13'd0 && occ == 13'd1;

`ifdef READBACK_OVF_CHECK_EN
  logic ovf;

  always_ff @(posedge clk) begin
    if (rst)
      ovf <= 1'b0;
    else if ((bus.rd_valid && full) ||
             (wr && res == 13'd0 && state == S_IDLE))
      ovf <= 1'b1;
  end

  assign bus.ovf_err = ovf;
`else
  assign bus.ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_readback_buffer.sv
// Bench for readback_buffer: queue-based model on a 1024-deep instance
// plus directed literal checks, including a 4-deep overflow instance.
module tb_readback_buffer;

  localparam int DA = 1024;
  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_FIN   = 3;

  logic clk;
  logic rst;

  readback_buffer_if bus_a ();
  readback_buffer_if bus_b ();

  readback_buffer #(.DEPTH(DA), .AW(10)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  readback_buffer #(.DEPTH(4), .AW(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name,
                       input logic [511:0] act,
                       input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [511:0] pat(input logic [7:0] tag,
                                       input int i);
    return {16{tag, 24'(i)}};
  endfunction

  // Behavioural model: queue of beats held, reservation count, run phase
  logic [511:0] q[$];
  int  res_m = 0;
  int  phase = P_IDLE;
  bit  armed_m = 1;
  bit  done_e = 0;
  bit  ovf_e = 0;
  int  space_e = 0;
  bit  started = 0;

  always @(posedge clk) begin
    int  sz0;
    bit  wr_m;
    bit  rd_m;
    bit  end_m;
    bit  to_drain;
    started = 1;
    if (rst) begin
      q.delete();
      res_m   = 0;
      phase   = P_IDLE;
      armed_m = 1;
      done_e  = 0;
      ovf_e   = 0;
      space_e = 0;
    end else begin
      sz0   = q.size();
      wr_m  = bus_a.rd_valid && sz0 < DA;
      rd_m  = sz0 > 0 && bus_a.out_ready;
      end_m = bus_a.softmc_end && armed_m;
`ifdef READBACK_OVF_CHECK_EN
      if ((bus_a.rd_valid && sz0 == DA) ||
          (wr_m && res_m == 0 && phase == P_IDLE))
        ovf_e = 1;
`endif
      if (rd_m) void'(q.pop_front());
      if (wr_m) q.push_back(bus_a.rd_data);
      if (bus_a.read_seq_incoming)
        res_m = res_m + int'(bus_a.read_size);
      if (wr_m && res_m > 0) res_m = res_m - 1;
      done_e = 0;
      to_drain = 0;
      case (phase)
        P_IDLE: begin
          if (end_m && sz0 == 0) to_drain = 1;
          else if (bus_a.read_seq_incoming || bus_a.rd_valid)
            phase = P_RUN;
        end
        P_RUN: if (end_m) to_drain = 1;
        P_DRAIN: begin
          if (res_m == 0 && q.size() == 0) begin
            phase = P_FIN;
            done_e = 1;
          end
        end
        default: phase = P_IDLE;
      endcase
      if (to_drain) phase = P_DRAIN;
      if (!bus_a.softmc_end) armed_m = 1;
      else if (to_drain) armed_m = 0;
      space_e = DA - q.size() - res_m;
      if (space_e < 0) space_e = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("m_valid", 512'(bus_a.out_valid), 512'(q.size() > 0));
      if (q.size() > 0)
        check("m_data", bus_a.out_data, q[0]);
      check("m_space", 512'(bus_a.buffer_space), 512'(space_e));
      check("m_last", 512'(bus_a.out_last),
            512'(q.size() == 1 && phase == P_DRAIN && res_m == 0));
      check("m_done", 512'(bus_a.done), 512'(done_e));
      check("m_ovf", 512'(bus_a.ovf_err), 512'(ovf_e));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [511:0] ovf_req;

  initial begin
`ifdef READBACK_OVF_CHECK_EN
    ovf_req = 512'd1;
`else
    ovf_req = 512'd0;
`endif
    rst = 1'b1;
    bus_a.rd_valid = 0; bus_a.rd_data = '0; bus_a.read_size = '0;
    bus_a.read_seq_incoming = 0; bus_a.softmc_end = 0;
    bus_a.out_ready = 0;
    bus_b.rd_valid = 0; bus_b.rd_data = '0; bus_b.read_size = '0;
    bus_b.read_seq_incoming = 0; bus_b.softmc_end = 0;
    bus_b.out_ready = 0;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("idle_space", 512'(bus_a.buffer_space), 512'd1024);
    check("idle_valid", 512'(bus_a.out_valid), 512'd0);
    check("idle_done", 512'(bus_a.done), 512'd0);
    check("idle_ovf", 512'(bus_a.ovf_err), 512'd0);

    bus_a.read_seq_incoming = 1; bus_a.read_size = 12'd8;
    tick();
    bus_a.read_seq_incoming = 0;
    check("resv_space", 512'(bus_a.buffer_space), 512'd1016);
    for (int i = 0; i < 8; i++) begin
      bus_a.rd_valid = 1; bus_a.rd_data = pat(8'hD0, i);
      tick();
    end
    bus_a.rd_valid = 0;
    check("fill_space", 512'(bus_a.buffer_space), 512'd1016);
    check("fill_head", bus_a.out_data, pat(8'hD0, 0));
    check("fill_ovf", 512'(bus_a.ovf_err), 512'd0);

    bus_a.out_ready = 1;
    repeat (8) tick();
    check("empty_valid", 512'(bus_a.out_valid), 512'd0);
    check("empty_space", 512'(bus_a.buffer_space), 512'd1024);
    for (int i = 0; i < 8; i++) begin
      bus_a.rd_valid = 1; bus_a.rd_data = pat(8'hE0, i);
      tick();
      check("stream_data", bus_a.out_data, pat(8'hE0, i));
    end
    bus_a.rd_valid = 0;
    tick();
    check("stream_end", 512'(bus_a.out_valid), 512'd0);

    bus_a.read_seq_incoming = 1; bus_a.read_size = 12'd4;
    bus_a.softmc_end = 1;
    tick();
    bus_a.read_seq_incoming = 0;
    for (int i = 0; i < 4; i++) begin
      bus_a.rd_valid = 1; bus_a.rd_data = pat(8'hF0, i);
      tick();
      check("drain_last", 512'(bus_a.out_last), 512'(i == 3));
    end
    check("drain_data", bus_a.out_data, pat(8'hF0, 3));
    bus_a.rd_valid = 0;
    tick();
    check("done_pulse", 512'(bus_a.done), 512'd1);
    check("done_valid", 512'(bus_a.out_valid), 512'd0);
    tick();
    check("done_once", 512'(bus_a.done), 512'd0);
    repeat (3) tick();
    check("done_held", 512'(bus_a.done), 512'd0);
    bus_a.softmc_end = 0;
    tick();

    bus_a.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus_a.rd_valid = 1; bus_a.rd_data = pat(8'hA0, i);
      tick();
    end
    bus_a.rd_valid = 0;
    check("pre_rst_valid", 512'(bus_a.out_valid), 512'd1);
    check("idle_write_ovf", 512'(bus_a.ovf_err), ovf_req);
    rst = 1;
    tick();
    rst = 0;
    check("rst_valid", 512'(bus_a.out_valid), 512'd0);
    check("rst_ovf", 512'(bus_a.ovf_err), 512'd0);
    tick();
    check("rst_space", 512'(bus_a.buffer_space), 512'd1024);
    bus_a.out_ready = 1;
    repeat (3) tick();
    check("rst_no_data", 512'(bus_a.out_valid), 512'd0);

    for (int i = 0; i < 5; i++) begin
      bus_b.rd_valid = 1; bus_b.rd_data = pat(8'hB0, i);
      tick();
    end
    bus_b.rd_valid = 0;
    check("b_space", 512'(bus_b.buffer_space), 512'd0);
    check("b_valid", 512'(bus_b.out_valid), 512'd1);
    check("b_ovf", 512'(bus_b.ovf_err), ovf_req);
    bus_b.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("b_data", bus_b.out_data, pat(8'hB0, i));
      tick();
    end
    check("b_drop", 512'(bus_b.out_valid), 512'd0);
    check("b_space_end", 512'(bus_b.buffer_space), 512'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/readback_buffer.md
Name: readback_buffer

Overview:
- Sits between the DDR PHY read-data return path and the host readback interface.
- Buffers 512-bit read beats and streams them to the host with a valid/ready handshake.
- Supplies the fetch stage's backpressure signals: it accepts read reservations (read_size, read_seq_incoming) and reports free space (buffer_space).
- Tracks program end (softmc_end), drains remaining data, and marks the final beat.

Parameters:
- DEPTH, 1024, number of 512-bit entries; legal range 2..4095; buffer_space is 12 bits.
- AW, 10, pointer width; must equal clog2(DEPTH).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rd_valid  input  1  PHY read beat valid
- rd_data  input  512  PHY read beat
- read_size  input  12  beats reserved by the upcoming read sequence
- read_seq_incoming  input  1  one-cycle pulse; reserves read_size beats
- softmc_end  input  1  level or pulse; program finished
- buffer_space  output  12  DEPTH - occupancy - reserved, floored at 0
- out_data  output  512  host beat
- out_valid  output  1  host beat valid
- out_ready  input  1  host accepts beat
- out_last  output  1  final beat of the run; qualified by out_valid
- done  output  1  one-cycle pulse when the run is fully drained
- ovf_err  output  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset: all outputs 0; occupancy, reserved, pointers and state cleared; buffer_space = DEPTH from the cycle after rst deasserts.
- Reset mid-operation discards all contents and reservations.
- Storage: circular RAM, wrap at DEPTH.
- Write when rd_valid=1 and not full. Read when out_valid=1 and out_ready=1.
- Output register: out_valid rises 1 cycle after the first write into an empty buffer.
- out_data/out_valid hold while out_valid=1 and out_ready=0.
- Back-to-back beats at full throughput when out_ready stays 1.
- Occupancy update: +1 on write, -1 on read; simultaneous write and read leaves it unchanged. Occupancy counts beats in RAM plus the output register.
- Reserved counter (13 bits):
  - +read_size on read_seq_incoming.
  - -1 on each accepted write while reserved > 0.
  - If both happen in the same cycle, net = +read_size-1.
  - Write with reserved = 0 is legal and consumes occupancy only.
- buffer_space: registered, updated every cycle from the next-state occupancy and reserved values; saturates at 0.
- Write while full (occupancy = DEPTH): beat dropped; pointers unchanged.
- State machine:
  - IDLE -> RUN on the first read_seq_incoming or rd_valid.
  - RUN -> DRAIN when softmc_end=1.
  - IDLE -> DRAIN when softmc_end=1 with nothing buffered.
  - DRAIN -> DONE when reserved = 0 and occupancy = 0.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Writes are still accepted in DRAIN until reserved reaches 0.
- out_last = out_valid and state = DRAIN and reserved = 0 and occupancy = 1.
- Simultaneous softmc_end and read_seq_incoming: the reservation is recorded, then DRAIN waits for it.
- softmc_end held high in IDLE after DONE does not retrigger until it deasserts (edge armed).

Optional Feature:
- Macro: READBACK_OVF_CHECK_EN.
- Defined: ovf_err sets on any dropped write, or any write arriving when reserved = 0 in state IDLE. It is sticky until rst.
- Not defined: ovf_err tied to 0 and the check logic is omitted. Dropped-write behaviour is unchanged.

Test Plan:
- Reset, then idle 5 cycles -> buffer_space=1024, out_valid=0, done=0, ovf_err=0.
- Pulse read_seq_incoming with read_size=8 -> buffer_space=1016 next cycle. Then 8 rd_valid beats with out_ready=0 -> buffer_space stays 1016, and occupancy reaches 8 while reserved reaches 0.
- Out_ready held 1; beats D0..D7 written consecutively -> out_data D0..D7 in order, one per cycle, first on the cycle after D0's write. No bubbles, no reordering.
- Reserve 4, softmc_end=1, 4 beats delivered -> out_last=1 only on the 4th beat. done pulses one cycle after that beat is accepted, then state is IDLE.
- With DEPTH=4: write 5 beats with out_ready=0 -> 5th beat dropped, buffer_space=0. ovf_err=1 with READBACK_OVF_CHECK_EN defined, 0 without.
- Fill 3 beats, assert rst for 1 cycle -> out_valid=0 and buffer_space=DEPTH next cycle. Buffered data is never presented.
